ula_seq: RTL
============

Name: ula_seq

Overview:
- Parametrised, registered successor of the 4-bit combinational ULA.
- Operand width is set by WIDTH. Opcode set grows from 4 to 8; the new ones are logic ops and an iterative multiply.
- Has a valid/ready handshake on both input and output, plus a full flag set (carry, zero, negative, overflow).
- Sits between the datapath register file and writeback. It accepts one operation at a time and holds its result until consumed.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)
SHW, $clog2(WIDTH)+1, width of the shift-amount field taken from B's LSBs

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept a request
A  in  WIDTH  operand A
B  in  WIDTH  operand B (shift amount for shifts)
sel  in  3  opcode (ula_pkg::op_e)
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts the result
resul  out  WIDTH  result, low WIDTH bits
resul_hi  out  WIDTH  high half of the product for MUL; 0 for all other ops
flag  out  1  carry/borrow, bit WIDTH of the extended result
zero  out  1  resul == 0 (MUL: full 2*WIDTH product == 0)
neg  out  1  resul[WIDTH-1] (MUL: resul_hi[WIDTH-1])
ovf  out  1  signed overflow for ADD/SUB; 0 otherwise

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0.
  - resul, resul_hi, flag, zero, neg, ovf all 0.
  - Any in-flight MUL is discarded.
- Opcodes (3'b): 000 ADD, 001 SUB, 010 SRL, 011 SLL, 100 AND, 101 OR, 110 XOR, 111 MUL.
- Arithmetic is computed in WIDTH+1 bits; flag = bit WIDTH.
  - ADD: carry out.
  - SUB: borrow, i.e. 1 iff A<B unsigned.
  - SLL: last bit shifted out of position WIDTH-1.
  - SRL: flag 0.
  - AND/OR/XOR: flag 0.
- Shifts use amount = B[SHW-1:0]. If amount >= WIDTH: resul=0; SLL flag = A[0] if amount==WIDTH, else 0.
- ovf: ADD = (A,B same sign) and result sign differs; SUB = (A,B differ in sign) and result sign differs from A.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. Handshake is in_valid & in_ready.
    - Opcodes 000–110: result registered at the next edge, state → DONE. Latency is 1 cycle from accept to out_valid.
    - MUL: operands latched, state → MUL.
  - MUL: unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles. Then state → DONE, so latency is WIDTH+1 cycles. in_ready=0 throughout.
  - DONE: out_valid=1. Outputs stay stable until out_valid & out_ready. in_ready=0.
    - On handshake, state → IDLE and out_valid deasserts the next cycle.
- No back-to-back overlap: a new request is accepted at the earliest one cycle after the result handshake.
- in_valid while in_ready=0 is ignored. The requester must hold A/B/sel until accepted.
- Outputs are held (not cleared) in IDLE after consumption.
- rst_n asserted during MUL or DONE → immediate return to the reset values above.

Decomposition:
- ula_pkg:
  - typedef enum logic [2:0] op_e {OP_ADD, OP_SUB, OP_SRL, OP_SLL, OP_AND, OP_OR, OP_XOR, OP_MUL}
  - typedef enum state_e {S_IDLE, S_MUL, S_DONE}
  - localparam OPW=3
- Sub-module ula_mul_iter (WIDTH): start / busy / done shift-add multiplier, instantiated once. The single-cycle ops stay in a combinational always_comb in ula_seq.

Test Plan (WIDTH=8):
1. Reset mid-MUL: accept MUL 200*3, pull rst_n low at cycle 4 → out_valid=0, in_ready=1 immediately; all outputs 0.
2. ADD carry and overflow:
   - ADD 8'hF0+8'h20 → 1 cycle later out_valid, resul=8'h10, flag=1, ovf=0, zero=0.
   - ADD 8'h7F+8'h01 → resul=8'h80, ovf=1, neg=1.
3. SUB borrow/zero:
   - SUB 5-7 → resul=8'hFE, flag=1, neg=1.
   - SUB 9-9 → resul=0, zero=1, flag=0.
4. Shift boundaries:
   - SLL 8'h81<<1 → resul=8'h02, flag=1.
   - SRL 8'hFF>>8 → resul=0, zero=1.
   - SLL 8'h01<<8 → resul=0, flag=1.
5. MUL latency/value: MUL 200*3 → out_valid exactly 9 cycles after accept, resul_hi=8'h02, resul=8'h58, zero=0; in_ready=0 throughout.
6. Backpressure: XOR 8'hAA^8'h0F with out_ready=0 for 5 cycles → resul=8'hA5 held stable, in_ready=0, extra in_valid pulses ignored. The result is consumed on out_ready=1 and in_ready returns the next cycle.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared opcode, FSM state and flag types for the sequential ULA.
package ula_pkg;

  localparam int unsigned OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SRL = 3'b010,
    OP_SLL = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/ula_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product.
module ula_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_c,
  output logic [2*WIDTH-1:0] prod_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic [WIDTH-1:0] addend_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] hi_nxt_c;
  logic [WIDTH-1:0] lo_nxt_c;

  // One iteration: conditionally add multiplicand to the high half, then shift right.
  always_comb begin
    addend_c = lo_q[0] ? mcand_q : '0;
    sum_c    = {1'b0, hi_q} + {1'b0, addend_c};
    hi_nxt_c = sum_c[WIDTH:1];
    lo_nxt_c = {sum_c[0], lo_q[WIDTH-1:1]};
  end

  // The final product is exposed combinationally so the caller can latch it on the last edge.
  assign done_c = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign prod_c = {hi_nxt_c, lo_nxt_c};
  assign busy_o = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      mcand_q <= a_i;
      hi_q    <= '0;
      lo_q    <= b_i;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      hi_q  <= hi_nxt_c;
      lo_q  <= lo_nxt_c;
      cnt_q <= cnt_q + CW'(1);
      if (done_c) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Registered ULA with valid/ready handshakes, flag set and an iterative multiply.
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resul,
  output logic [WIDTH-1:0] resul_hi,
  output logic             flag,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  flags_t           flg_q, flg_d;
  logic             in_ready_q;
  logic             out_valid_q;

  op_e              op_c;
  logic [SHW-1:0]   amt_c;
  logic [WIDTH:0]   ext_c;
  logic             ovf_c;
  logic             accept_c;

  logic               mul_start_c;
  logic               mul_busy;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;

  assign op_c        = op_e'(sel);
  assign amt_c       = B[SHW-1:0];
  assign accept_c    = (state_q == S_IDLE) && in_valid;
  assign mul_start_c = accept_c && (op_c == OP_MUL);

  ula_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start_c),
    .a_i     (A),
    .b_i     (B),
    .busy_o  (mul_busy),
    .done_c  (mul_done_c),
    .prod_c  (mul_prod_c)
  );

  // Single-cycle ops in WIDTH+1 bits; bit WIDTH is carry, borrow or the last bit shifted out.
  always_comb begin
    ext_c = '0;
    ovf_c = 1'b0;
    case (op_c)
      OP_ADD: begin
        ext_c = {1'b0, A} + {1'b0, B};
        ovf_c = (A[WIDTH-1] == B[WIDTH-1]) && (ext_c[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        ext_c = {1'b0, A} - {1'b0, B};
        ovf_c = (A[WIDTH-1] != B[WIDTH-1]) && (ext_c[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SRL:  ext_c = {1'b0, A >> amt_c};
      OP_SLL:  ext_c = {1'b0, A} << amt_c;
      OP_AND:  ext_c = {1'b0, A & B};
      OP_OR:   ext_c = {1'b0, A | B};
      OP_XOR:  ext_c = {1'b0, A ^ B};
      default: ext_c = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    flg_d   = flg_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (op_c == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DONE;
            res_d   = ext_c[WIDTH-1:0];
            hi_d    = '0;
            flg_d.c = ext_c[WIDTH];
            flg_d.z = (ext_c[WIDTH-1:0] == '0);
            flg_d.n = ext_c[WIDTH-1];
            flg_d.v = ovf_c;
          end
        end
      end
      S_MUL: begin
        if (mul_done_c) begin
          state_d = S_DONE;
          res_d   = mul_prod_c[WIDTH-1:0];
          hi_d    = mul_prod_c[2*WIDTH-1:WIDTH];
          flg_d.c = 1'b0;
          flg_d.z = (mul_prod_c == '0);
          flg_d.n = mul_prod_c[2*WIDTH-1];
          flg_d.v = 1'b0;
        end else if (!mul_busy) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      res_q       <= '0;
      hi_q        <= '0;
      flg_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      hi_q        <= hi_d;
      flg_q       <= flg_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign resul     = res_q;
  assign resul_hi  = hi_q;
  assign flag      = flg_q.c;
  assign zero      = flg_q.z;
  assign neg       = flg_q.n;
  assign ovf       = flg_q.v;

endmodule
